// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer: clears the register file, streams a program into memory,
// then releases the CPU reset for a fixed budget of cycles.
module cpu_boot_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16,
  parameter int INIT_MODE      = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_WIDTH-1:0]      run_cycles,
  input  logic                      load_valid,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic                      load_last,
  output logic                      load_ready,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      cpu_reset,
  output logic                      busy,
  output logic                      done,
  output logic                      load_error,
  output logic [CNT_WIDTH-1:0]      cycle_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REG  = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]                state;
  logic [REG_ADDR_WIDTH-1:0] reg_cnt;
  logic [MEM_ADDR_WIDTH-1:0] mem_cnt;
  logic [CNT_WIDTH-1:0]      run_lat;
  logic [CNT_WIDTH-1:0]      cycle_nxt;
  logic                      reg_last;
  logic                      mem_full;

  assign reg_last  = reg_cnt == REG_ADDR_WIDTH'(REG_COUNT - 1);
  assign mem_full  = &mem_cnt;
  assign cycle_nxt = cycle_count + CNT_WIDTH'(1);

  assign load_ready = state == S_MEM;
  assign reg_we     = state == S_REG;
  assign mem_we     = load_ready && load_valid;
  assign cpu_reset  = state == S_RUN;
  assign done       = state == S_DONE;
  assign busy       = reg_we || load_ready || cpu_reset;

  // Register 0 is hard-wired to zero on the CPU side, so it never gets i.
  always_comb begin
    reg_wdata = '0;
    if (reg_we && INIT_MODE == 1 && reg_cnt != '0)
      reg_wdata = DATA_WIDTH'(reg_cnt);
  end

  assign reg_waddr = reg_we ? reg_cnt : '0;
  assign mem_waddr = mem_we ? mem_cnt : '0;
  assign mem_wdata = mem_we ? load_data : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      reg_cnt     <= '0;
      mem_cnt     <= '0;
      run_lat     <= '0;
      cycle_count <= '0;
      load_error  <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_REG;
            run_lat     <= run_cycles;
            cycle_count <= '0;
            load_error  <= 1'b0;
            reg_cnt     <= '0;
            mem_cnt     <= '0;
          end
        end
        S_REG: begin
          reg_cnt <= reg_cnt + REG_ADDR_WIDTH'(1);
          if (reg_last)
            state <= S_MEM;
        end
        S_MEM: begin
          if (load_valid) begin
            mem_cnt <= mem_cnt + MEM_ADDR_WIDTH'(1);
            if (load_last) begin
              state <= (run_lat == '0) ? S_DONE : S_RUN;
            end else if (mem_full) begin
              load_error <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_RUN: begin
          cycle_count <= cycle_nxt;
          if (cycle_nxt == run_lat)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
// Directed bench: default instance (a) and an INIT_MODE=0, 4-word memory
// instance (b) share one stimulus stream.
module tb_cpu_boot_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] run_cycles = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;

  logic        a_load_ready, a_reg_we, a_mem_we, a_cpu_reset;
  logic        a_busy, a_done, a_load_error;
  logic [4:0]  a_reg_waddr;
  logic [31:0] a_reg_wdata, a_mem_wdata;
  logic [7:0]  a_mem_waddr;
  logic [15:0] a_cycle_count;

  logic        b_load_ready, b_reg_we, b_mem_we, b_cpu_reset;
  logic        b_busy, b_done, b_load_error;
  logic [4:0]  b_reg_waddr;
  logic [31:0] b_reg_wdata, b_mem_wdata;
  logic [1:0]  b_mem_waddr;
  logic [15:0] b_cycle_count;

  cpu_boot_sequencer u_a (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .run_cycles(run_cycles), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(a_load_ready), .reg_we(a_reg_we),
    .reg_waddr(a_reg_waddr), .reg_wdata(a_reg_wdata),
    .mem_we(a_mem_we), .mem_waddr(a_mem_waddr),
    .mem_wdata(a_mem_wdata), .cpu_reset(a_cpu_reset),
    .busy(a_busy), .done(a_done), .load_error(a_load_error),
    .cycle_count(a_cycle_count)
  );

  cpu_boot_sequencer #(.MEM_ADDR_WIDTH(2), .INIT_MODE(0)) u_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .run_cycles(run_cycles), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(b_load_ready), .reg_we(b_reg_we),
    .reg_waddr(b_reg_waddr), .reg_wdata(b_reg_wdata),
    .mem_we(b_mem_we), .mem_waddr(b_mem_waddr),
    .mem_wdata(b_mem_wdata), .cpu_reset(b_cpu_reset),
    .busy(b_busy), .done(b_done), .load_error(b_load_error),
    .cycle_count(b_cycle_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int a_reg_n, a_reg_bad, a_mem_n, a_mem_bad, a_run_n;
  int b_reg_n, b_reg_bad, b_mem_n, b_mem_bad, b_run_n;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        last;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    a_reg_n = 0; a_reg_bad = 0; a_mem_n = 0; a_mem_bad = 0; a_run_n = 0;
    b_reg_n = 0; b_reg_bad = 0; b_mem_n = 0; b_mem_bad = 0; b_run_n = 0;
  endtask

  // One clock: sample at the falling edge, return 1 time unit after rising.
  task automatic step();
    @(negedge clock);
    if (a_reg_we) begin
      if (a_reg_waddr !== 5'(a_reg_n) || a_reg_wdata !== 32'(a_reg_n))
        a_reg_bad++;
      a_reg_n++;
    end
    if (b_reg_we) begin
      if (b_reg_waddr !== 5'(b_reg_n) || b_reg_wdata !== 32'd0)
        b_reg_bad++;
      b_reg_n++;
    end
    if (a_mem_we) begin
      if (a_mem_waddr !== 8'(a_mem_n) || a_mem_wdata !== load_data ||
          !load_valid)
        a_mem_bad++;
      a_mem_n++;
    end
    if (b_mem_we) begin
      if (b_mem_waddr !== 2'(b_mem_n) || b_mem_wdata !== load_data ||
          !load_valid)
        b_mem_bad++;
      b_mem_n++;
    end
    if (a_cpu_reset) a_run_n++;
    if (b_cpu_reset) b_run_n++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [15:0] rc);
    run_cycles = rc;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", a_busy, 1);
  endtask

  task automatic wait_mem(input string name);
    int n;
    n = 0;
    while (!a_load_ready && n < 100) begin
      step();
      n++;
    end
    check({name, "_reg_cycles"}, n, 32);
    check({name, "_a_reg_n"}, a_reg_n, 32);
    check({name, "_a_reg_bad"}, a_reg_bad, 0);
    check({name, "_b_reg_n"}, b_reg_n, 32);
    check({name, "_b_reg_bad"}, b_reg_bad, 0);
  endtask

  task automatic word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[1] = '{1'b0, 32'hEE, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[3] = '{1'b0, 32'hEE, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[5] = '{1'b0, 32'hEE, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[6] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 8'd3};

    clear_mon();
    #3 reset = 1'b0;
    #2;
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_cpu_reset", a_cpu_reset, 0);
    check("rst_load_ready", a_load_ready, 0);
    check("rst_reg_we", a_reg_we, 0);
    check("rst_cycle_count", a_cycle_count, 0);
    check("rst_load_error", a_load_error, 0);
    step();
    reset = 1'b1;
    repeat (3) step();
    check("idle_hold_busy", a_busy, 0);
    check("idle_hold_reg_we", a_reg_we, 0);

    // Full boot, INIT_MODE 1 and 0, valid toggling, 4 words, 10 run cycles.
    clear_mon();
    do_start(16'd10);
    wait_mem("boot");
    for (int i = 0; i < 7; i++) begin
      load_valid = tbl[i].v;
      load_data  = tbl[i].d;
      load_last  = tbl[i].last;
      #1;
      check($sformatf("vec%0d_ready", i), a_load_ready, tbl[i].ready);
      check($sformatf("vec%0d_we", i), a_mem_we, tbl[i].we);
      check($sformatf("vec%0d_b_we", i), b_mem_we, tbl[i].we);
      if (tbl[i].we)
        check($sformatf("vec%0d_addr", i), a_mem_waddr, tbl[i].addr);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    n = 0;
    while (!a_done && n < 40) begin
      step();
      n++;
    end
    check("boot_run_len", a_run_n, 10);
    check("boot_b_run_len", b_run_n, 10);
    check("boot_done", a_done, 1);
    check("boot_b_done", b_done, 1);
    check("boot_busy", a_busy, 0);
    check("boot_cpu_reset", a_cpu_reset, 0);
    check("boot_cycle_count", a_cycle_count, 10);
    check("boot_a_mem_n", a_mem_n, 4);
    check("boot_b_mem_n", b_mem_n, 4);
    check("boot_a_mem_bad", a_mem_bad, 0);
    check("boot_b_mem_bad", b_mem_bad, 0);

    // Overflow: b has 4 words of memory, 5 words offered without last.
    clear_mon();
    do_start(16'd5);
    wait_mem("ovf");
    for (int i = 0; i < 5; i++) word(32'd100 + 32'(i), 1'b0);
    check("ovf_b_done", b_done, 1);
    check("ovf_b_load_error", b_load_error, 1);
    check("ovf_b_mem_n", b_mem_n, 4);
    check("ovf_b_mem_bad", b_mem_bad, 0);
    check("ovf_b_run_n", b_run_n, 0);
    check("ovf_a_mem_n", a_mem_n, 5);
    check("ovf_a_ready", a_load_ready, 1);
    check("ovf_a_load_error", a_load_error, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ovf_abort_a_busy", a_busy, 0);
    check("ovf_abort_b_done", b_done, 0);
    check("ovf_abort_b_err_held", b_load_error, 1);

    // Zero run budget skips RUN entirely.
    clear_mon();
    do_start(16'd0);
    check("zero_b_err_cleared", b_load_error, 0);
    wait_mem("zero");
    word(32'h55, 1'b1);
    check("zero_done", a_done, 1);
    check("zero_cpu_reset", a_cpu_reset, 0);
    repeat (3) step();
    check("zero_run_n", a_run_n, 0);
    check("zero_cycle_count", a_cycle_count, 0);
    check("zero_done_hold", a_done, 1);

    // Abort after 3 RUN cycles; start during RUN is ignored.
    clear_mon();
    do_start(16'd20);
    wait_mem("abrt");
    word(32'h77, 1'b1);
    check("abrt_in_run", a_cpu_reset, 1);
    start = 1'b1;
    run_cycles = 16'd0;
    step();
    start = 1'b0;
    step();
    step();
    check("abrt_cnt_before", a_cycle_count, 3);
    check("abrt_still_run", a_cpu_reset, 1);
    check("abrt_no_restart", a_reg_n, 32);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abrt_busy", a_busy, 0);
    check("abrt_cpu_reset", a_cpu_reset, 0);
    check("abrt_cycle_count", a_cycle_count, 3);
    repeat (2) step();
    check("abrt_idle_hold", a_busy, 0);
    check("abrt_cnt_hold", a_cycle_count, 3);

    // Asynchronous reset in MEM_LOAD, then a clean restart.
    clear_mon();
    do_start(16'd2);
    wait_mem("ares");
    word(32'h1, 1'b0);
    word(32'h2, 1'b0);
    load_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("ares_ready", a_load_ready, 0);
    check("ares_mem_we", a_mem_we, 0);
    check("ares_busy", a_busy, 0);
    check("ares_done", a_done, 0);
    check("ares_cpu_reset", a_cpu_reset, 0);
    check("ares_mem_waddr", a_mem_waddr, 0);
    load_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("ares_idle", a_busy, 0);
    clear_mon();
    do_start(16'd2);
    wait_mem("rest");
    word(32'h9, 1'b1);
    n = 0;
    while (!a_done && n < 20) begin
      step();
      n++;
    end
    check("rest_done", a_done, 1);
    check("rest_cycle_count", a_cycle_count, 2);
    check("rest_run_n", a_run_n, 2);
    check("rest_mem_addr0", a_mem_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

endmodule

// File: doc/cpu_boot_sequencer.md
CPU_BOOT_SEQUENCER -- requirements
Module: cpu_boot_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of register and memory data words.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 8, giving a program memory depth of 2**MEM_ADDR_WIDTH words.
REQ-003 SHALL have parameter REG_COUNT, default 32, number of register-file entries to initialise.
REQ-004 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, width of the run-cycle budget and counter.
REQ-006 SHALL have parameter INIT_MODE, default 1; 0 = all registers zero, 1 = register i gets value i.
REQ-007 SHALL have port: clock  in  1  the single clock; all logic is rising-edge triggered.
REQ-008 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port: start  in  1  begins a boot-and-run sequence.
REQ-010 SHALL have port: abort  in  1  cancels any sequence in progress.
REQ-011 SHALL have port: run_cycles  in  CNT_WIDTH  number of cycles the CPU runs; latched when start is accepted.
REQ-012 SHALL have port: load_valid  in  1  program word available.
REQ-013 SHALL have port: load_data  in  DATA_WIDTH  program word.
REQ-014 SHALL have port: load_last  in  1  marks the final program word.
REQ-015 SHALL have port: load_ready  out  1  sequencer accepts a program word.
REQ-016 SHALL have ports: reg_we, reg_waddr, reg_wdata  out  1 / REG_ADDR_WIDTH / DATA_WIDTH  register-file write port.
REQ-017 SHALL have ports: mem_we, mem_waddr, mem_wdata  out  1 / MEM_ADDR_WIDTH / DATA_WIDTH  program-memory write port.
REQ-018 SHALL have port: cpu_reset  out  1  active-low reset driven to the CPU.
REQ-019 SHALL have ports: busy, done, load_error  out  1 each  status.
REQ-020 SHALL have port: cycle_count  out  CNT_WIDTH  CPU cycles executed in the current or last run.

Function
REQ-021 SHALL implement states IDLE, REG_INIT, MEM_LOAD, RUN, DONE.
REQ-022 IDLE or DONE with start=1 SHALL go to REG_INIT next cycle, latching run_cycles and clearing cycle_count, load_error, done, and both address counters.
REQ-023 start SHALL be ignored in REG_INIT, MEM_LOAD and RUN.
REQ-024 REG_INIT SHALL assert reg_we for exactly REG_COUNT consecutive cycles, with addresses 0..REG_COUNT-1 in order; reg_wdata per INIT_MODE, except that address 0 always receives 0.
REQ-025 After the write to address REG_COUNT-1, the state SHALL go to MEM_LOAD.
REQ-026 MEM_LOAD SHALL hold load_ready=1; a word transfers only on a cycle with load_valid=1 and load_ready=1.
REQ-027 Each transfer SHALL assert mem_we that cycle, driving mem_waddr = word counter and mem_wdata = load_data, and SHALL then increment the counter.
REQ-028 A transfer with load_last=1 SHALL move the state to RUN, or to DONE if the latched run_cycles is 0.
REQ-029 A transfer at address 2**MEM_ADDR_WIDTH-1 with load_last=0 SHALL still write that word, set load_error sticky, and go to DONE without entering RUN.
REQ-030 cpu_reset SHALL be 1 only in RUN and 0 in every other state.
REQ-031 In RUN, cycle_count SHALL increment once per cycle; when it reaches the latched run_cycles, the state SHALL go to DONE, so cpu_reset is high for exactly run_cycles cycles.
REQ-032 done SHALL be 1 throughout DONE; busy SHALL be 1 in REG_INIT, MEM_LOAD and RUN.
REQ-033 reg_we, mem_we and load_ready SHALL be 0 outside their own states.
REQ-034 abort=1 in any state other than IDLE SHALL force IDLE on the next edge with cpu_reset=0, and SHALL take priority over every other transition.
REQ-035 cycle_count and load_error SHALL hold their values after an abort.

Reset
REQ-036 reset=0 SHALL immediately force IDLE, cpu_reset=0, and all other outputs and counters to 0, including in the middle of a sequence.
REQ-037 After reset is released, the block SHALL stay in IDLE until start is accepted.

Verification
REQ-038 Defaults, INIT_MODE=1, start with run_cycles=10, 4 words with last on the 4th: -> 32 register writes with data 0..31, mem writes to addresses 0..3, cpu_reset high for exactly 10 cycles, then done=1 and cycle_count=10.
REQ-039 INIT_MODE=0 and load_valid toggling every other cycle: -> all 32 reg_wdata = 0, one mem write per accepted word only, addresses contiguous.
REQ-040 MEM_ADDR_WIDTH=2, 5 words, no load_last: -> addresses 0..3 written, load_error=1, done=1, cpu_reset never high.
REQ-041 run_cycles=0: -> goes directly from MEM_LOAD to DONE, cpu_reset never high, cycle_count=0.
REQ-042 abort in RUN after 3 cycles: -> IDLE next edge, cpu_reset=0, cycle_count=3; start pulsed during RUN has no effect.
REQ-043 reset=0 during MEM_LOAD: -> all outputs 0 asynchronously; a later start restarts the sequence from register 0.
